rej_ntt_coeff_sampler: RTL and testbench

//  Coefficient parser between the SHAKE128 sponge squeeze port and matrix-A RAM port a.

---
 rtl/rej_ntt_coeff_sampler.sv | 169 ++++++++++++++++
 tb/tb_rej_ntt_coeff_sampler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rej_ntt_coeff_sampler.sv
// Rejection sampler: cuts the SHAKE128 squeeze stream into 3-byte candidates and writes every
// coefficient below Q to matrix-A RAM. Optional statistics counter under `REJ_SAMPLER_STATS_EN.
module rej_ntt_coeff_sampler #(
    parameter int N             = 256,
    parameter int K             = 8,
    parameter int L             = 7,
    parameter int COEFF_WIDTH   = 24,
    parameter int DATA_OUT_BITS = 64,
    parameter int Q             = 8380417
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [3:0]                    k,
    input  logic [3:0]                    l,
    input  logic [DATA_OUT_BITS-1:0]      shake_data_out,
    input  logic                          out_valid,
    output logic                          out_ready,
    output logic                          we_matA,
    output logic [$clog2(K*L*N)-1:0]      addr_matA,
    output logic [COEFF_WIDTH-1:0]        din_matA,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   rej_count
);

    localparam int WORD_BYTES = DATA_OUT_BITS / 8;
    localparam int BUF_BYTES  = WORD_BYTES + 2;
    localparam int BUF_BITS   = 8 * BUF_BYTES;
    localparam int CNT_W      = $clog2(BUF_BYTES + 1);
    localparam int ADDR_W     = $clog2(K*L*N);
    localparam int N_W        = $clog2(N + 1);
    localparam logic [22:0] Q_C = 23'(Q);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state_q, state_d;
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   base;
    logic [22:0]         cand;
    logic                cand_ok;
    logic                valid_kl;
    logic                take;
    logic                accept;
    logic                reject;
    logic                done_d;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [COEFF_WIDTH-1:0] din_p1;
    logic                done_p1;

    // Top bit of the third byte is dropped before the range test.
    assign cand     = {buf_q[22:16], buf_q[15:0]};
    assign cand_ok  = (cand < Q_C);
    assign valid_kl = (int'(k) < K) && (int'(l) < L);
    assign base     = ADDR_W'(int'(k) * (L*N) + int'(l) * N);
    assign accept   = take && cand_ok;
    assign reject   = take && !cand_ok;
    assign done_d   = ((state_q == FIN) && !start) || (start && !valid_kl);

    assign out_ready = (state_q == RUN) && (cnt_q < CNT_W'(3));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        if (start) begin
            buf_d   = '0;
            cnt_d   = '0;
            n_d     = '0;
            ptr_d   = base;
            state_d = valid_kl ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q >= CNT_W'(3)) begin
                        take  = 1'b1;
                        buf_d = buf_q >> 24;
                        cnt_d = cnt_q - CNT_W'(3);
                        if (cand_ok) begin
                            n_d   = n_q + N_W'(1);
                            ptr_d = ptr_q + ADDR_W'(1);
                            // Last coefficient: leftover bytes are thrown away.
                            if (n_q == N_W'(N-1)) begin
                                state_d = FIN;
                                buf_d   = '0;
                                cnt_d   = '0;
                            end
                        end
                    end else if (out_valid) begin
                        buf_d = buf_q | (BUF_BITS'(shake_data_out) << {cnt_q, 3'b000});
                        cnt_d = cnt_q + CNT_W'(WORD_BYTES);
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stage p1: registered RAM write port and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            din_p1  <= '0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= accept;
            done_p1 <= done_d;
            if (accept) begin
                addr_p1 <= ptr_q;
                din_p1  <= COEFF_WIDTH'(cand);
            end
        end
    end

    assign we_matA   = vld_p1;
    assign addr_matA = addr_p1;
    assign din_matA  = din_p1;
    assign done      = done_p1;

`ifdef REJ_SAMPLER_STATS_EN
    logic [15:0] rej_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_q <= '0;
        end else if (start) begin
            rej_q <= '0;
        end else if (reject) begin
            rej_q <= sat_inc16(rej_q);
        end
    end

    assign rej_count = rej_q;
`else
    assign rej_count = '0;
`endif

endmodule

// File: tb/tb_rej_ntt_coeff_sampler.sv
// Directed bench for rej_ntt_coeff_sampler: vector table of short streams, then
// full-polynomial, restart, reset and invalid-index sequences.
module tb_rej_ntt_coeff_sampler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  k;
    logic [3:0]  l;
    logic [63:0] shake_data_out;
    logic        out_valid;
    logic        out_ready;
    logic        we_matA;
    logic [13:0] addr_matA;
    logic [23:0] din_matA;
    logic        busy;
    logic        done;
    logic [15:0] rej_count;

    rej_ntt_coeff_sampler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k), .l(l),
        .shake_data_out(shake_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .we_matA(we_matA), .addr_matA(addr_matA), .din_matA(din_matA),
        .busy(busy), .done(done), .rej_count(rej_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_we_cyc = 0;
    logic        done_busy = 1'b0;
    logic [13:0] wa[$];
    logic [23:0] wd[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_matA) begin
            wa.push_back(addr_matA);
            wd.push_back(din_matA);
            last_we_cyc <= cyc;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= busy;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic start_poly(input logic [3:0] kk, input logic [3:0] ll);
        start = 1'b1; k = kk; l = ll;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        bit ok;
        out_valid = 1'b0;
        repeat (gap) @(negedge clk);
        out_valid = 1'b1;
        shake_data_out = w;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_word: out_ready never rose, got 0 expected 1");
        end else begin
            @(negedge clk);
        end
        out_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]       k;
        logic [3:0]       l;
        logic [63:0]      w0;
        logic [63:0]      w1;
        int               nwr;
        logic [13:0]      base;
        logic [4:0][23:0] d;
        int               rej;
    } vec_t;

    vec_t        tv[4];
    logic [7:0]  sb[1200];
    logic [22:0] exp4[256];
    logic [22:0] c;
    logic [63:0] w;
    int          o, d0, errs, idx, acc, rejm, words4;

    initial begin
        // Cands 1,2 then 03 00 carried; second word of zeros gives 3,0,0.
        tv[0].k = 0; tv[0].l = 0; tv[0].base = 14'd0;
        tv[0].w0 = 64'h0003000002000001; tv[0].w1 = 64'h0;
        tv[0].nwr = 5; tv[0].rej = 0;
        tv[0].d = {24'd0, 24'd0, 24'd3, 24'd2, 24'd1};
        // 0x7FFFFF and Q rejected; Q-1, 5 (top bit masked), 0x563412 accepted.
        tv[1].k = 1; tv[1].l = 2; tv[1].base = 14'd2304;
        tv[1].w0 = 64'hE0007FE0017FFFFF; tv[1].w1 = 64'hAA5634128000057F;
        tv[1].nwr = 3; tv[1].rej = 2;
        tv[1].d = {24'd0, 24'd0, 24'h563412, 24'd5, 24'd8380416};
        // All 0xFF bytes: every candidate is 0x7FFFFF.
        tv[2].k = 7; tv[2].l = 6; tv[2].base = 14'd14080;
        tv[2].w0 = 64'hFFFFFFFFFFFFFFFF; tv[2].w1 = 64'hFFFFFFFFFFFFFFFF;
        tv[2].nwr = 0; tv[2].rej = 5;
        tv[2].d = '0;
        // 00 E0 FF -> Q-1; 02 E0 7F -> Q+1 rejected; FF FF 00; 00 00 80 -> 0; AB CD 3F.
        tv[3].k = 3; tv[3].l = 5; tv[3].base = 14'd6656;
        tv[3].w0 = 64'hFFFF7FE002FFE000; tv[3].w1 = 64'h003FCDAB80000000;
        tv[3].nwr = 4; tv[3].rej = 1;
        tv[3].d = {24'd0, 24'h3FCDAB, 24'd0, 24'h00FFFF, 24'h7FE000};

        rst_n = 1'b0; start = 1'b0; k = 0; l = 0; out_valid = 1'b0; shake_data_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", we_matA, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", out_ready, 0);
        chk("rst_addr", addr_matA, 0);
        chk("rst_din", din_matA, 0);
        chk("rst_rej", rej_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            o = wa.size();
            d0 = done_cnt;
            start_poly(tv[v].k, tv[v].l);
            chk("vec_busy", busy, 1);
            send_word(tv[v].w0, 0);
            send_word(tv[v].w1, 0);
            repeat (8) @(negedge clk);
            chk("vec_nwr", wa.size() - o, tv[v].nwr);
            for (int i = 0; i < tv[v].nwr; i++) begin
                if (o + i < wa.size()) begin
                    chk("vec_addr", wa[o+i], tv[v].base + 14'(i));
                    chk("vec_din", wd[o+i], tv[v].d[i]);
                end
            end
`ifdef REJ_SAMPLER_STATS_EN
            chk("vec_rej", rej_count, tv[v].rej);
`else
            chk("vec_rej", rej_count, 0);
`endif
            chk("vec_nodone", done_cnt - d0, 0);
        end

        // Full polynomial of zeros with random valid gaps: 96 words = 256 candidates.
        o = wa.size();
        d0 = done_cnt;
        start_poly(4'd7, 4'd6);
        for (int i = 0; i < 96; i++) send_word(64'h0, int'($urandom_range(0, 3)));
        for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t3_nwr", wa.size() - o, 256);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (o + i >= wa.size()) errs++;
            else if (wa[o+i] !== 14'(14080 + i) || wd[o+i] !== 24'd0) errs++;
        end
        chk("t3_seq_errs", errs, 0);
        chk("t3_done_once", done_cnt - d0, 1);
        chk("t3_done_lat", done_cyc - last_we_cyc, 1);
        chk("t3_done_busy", done_busy, 0);
        chk("t3_ready_after", out_ready, 0);
        chk("t3_busy_after", busy, 0);

        // Pseudo-random stream with forced reject candidates; byte-level reference.
        for (int i = 0; i < 1200; i++) sb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) begin
            sb[30*i] = 8'hFF; sb[30*i+1] = 8'hFF; sb[30*i+2] = 8'hFF;
        end
        sb[3] = 8'h01; sb[4] = 8'hE0; sb[5] = 8'h7F;
        sb[6] = 8'h00; sb[7] = 8'hE0; sb[8] = 8'h7F;
        acc = 0; idx = 0; rejm = 0;
        while (acc < 256 && idx + 2 < 1200) begin
            c = {sb[idx+2][6:0], sb[idx+1], sb[idx]};
            idx += 3;
            if (c < 23'd8380417) begin
                exp4[acc] = c;
                acc++;
            end else begin
                rejm++;
            end
        end
        words4 = (idx + 7) / 8;
        o = wa.size();
        d0 = done_cnt;
        start_poly(4'd4, 4'd1);
        for (int wi = 0; wi < words4; wi++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = sb[8*wi + b];
            send_word(w, int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t4_nwr", wa.size() - o, 256);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (o + i >= wa.size()) errs++;
            else if (wa[o+i] !== 14'(7424 + i) || wd[o+i] !== {1'b0, exp4[i]}) errs++;
        end
        chk("t4_coeff_errs", errs, 0);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_ready_after", out_ready, 0);
`ifdef REJ_SAMPLER_STATS_EN
        chk("t4_rej", rej_count, rejm);
`else
        chk("t4_rej", rej_count, 0);
`endif

        // Restart after 101 writes; the aborted polynomial must not report done.
        o = wa.size();
        d0 = done_cnt;
        start_poly(4'd0, 4'd1);
        for (int i = 0; i < 38; i++) send_word(64'h0, 0);
        repeat (6) @(negedge clk);
        chk("t5_first_nwr", wa.size() - o, 101);
        o = wa.size();
        start_poly(4'd2, 4'd3);
        send_word(64'h0000000000000007, 0);
        repeat (6) @(negedge clk);
        chk("t5_restart_nwr", wa.size() - o, 2);
        if (wa.size() >= o + 2) begin
            chk("t5_addr0", wa[o], 14'd4352);
            chk("t5_din0", wd[o], 24'd7);
            chk("t5_addr1", wa[o+1], 14'd4353);
        end
        chk("t5_nodone", done_cnt - d0, 0);

        send_word(64'h0, 0);
        for (int i = 0; i < 20 && !we_matA; i++) @(negedge clk);
        chk("t5_we_before_rst", we_matA, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_we", we_matA, 0);
        chk("t5_arst_busy", busy, 0);
        chk("t5_arst_addr", addr_matA, 0);
        chk("t5_arst_ready", out_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Out-of-range indices: immediate done, never busy, no writes.
        o = wa.size();
        start_poly(4'd8, 4'd0);
        chk("t6_k_done", done, 1);
        chk("t6_k_busy", busy, 0);
        @(negedge clk);
        chk("t6_k_done_end", done, 0);
        start_poly(4'd0, 4'd7);
        chk("t6_l_done", done, 1);
        chk("t6_l_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_writes", wa.size() - o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
